// File: rtl/mystruct_pkg.sv
// Shared types for the two-field packed word and the serializer FSM.
package mystruct_pkg;

   // Packed word: upper pair is the field sent second, lower pair goes first.
   typedef struct packed {
      logic [1:0] last;
      logic [1:0] first;
   } mystruct_t;

   localparam int FIELD_W = 2;
   localparam int WORD_W  = $bits(mystruct_t);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      LAST  = 2'd2
   } ser_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
// Exposes the head entry and the entry behind it so a consumer can
// reload from the next word in the same cycle it pops the current one.
module sync_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  T                           wdata,
   input  logic                       pop,
   output T                           head,
   output T                           head_next,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   T                 mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head      = mem[rd_ptr];
   assign head_next = mem[ptr_inc(rd_ptr)];

   // Storage write; contents need no reset since the count gates their use.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers and occupancy; simultaneous push and pop keep the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/struct_field_serializer.sv
// Serializes buffered two-field words into 2-bit beats: first field, then
// last field flagged with out_last. The word is popped on the last beat's
// handshake, so the occupancy count includes the word being sent.
module struct_field_serializer
   import mystruct_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WORD_W-1:0]          in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [FIELD_W-1:0]         out_data,
   output logic                       out_last,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   ser_state_t         state;
   ser_state_t         state_d;
   logic               valid_d;
   logic [FIELD_W-1:0] data_d;
   logic               last_d;

   mystruct_t          in_word;
   mystruct_t          head;
   mystruct_t          head_next;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;

   assign in_word  = mystruct_t'(in_data);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   assign pop      = (state == LAST) && out_ready;

   sync_fifo #(
      .T     (mystruct_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .wdata     (in_word),
      .pop       (pop),
      .head      (head),
      .head_next (head_next),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   // Next-state and next-output selection; default is to hold every output.
   always_comb begin
      state_d = state;
      valid_d = out_valid;
      data_d  = out_data;
      last_d  = out_last;
      case (state)
         IDLE: begin
            if (!empty) begin
               valid_d = 1'b1;
               data_d  = head.first;
               last_d  = 1'b0;
               state_d = FIRST;
            end else begin
               valid_d = 1'b0;
            end
         end
         FIRST: begin
            if (out_ready) begin
               data_d  = head.last;
               last_d  = 1'b1;
               state_d = LAST;
            end
         end
         LAST: begin
            if (out_ready) begin
               // Count is sampled before this cycle's push, so a word
               // arriving now is only picked up from IDLE next cycle.
               if (fifo_count > CNT_W'(1)) begin
                  valid_d = 1'b1;
                  data_d  = head_next.first;
                  last_d  = 1'b0;
                  state_d = FIRST;
               end else begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else begin
         state     <= state_d;
         out_valid <= valid_d;
         out_data  <= data_d;
         out_last  <= last_d;
      end
   end

endmodule

// File: tb/tb_struct_field_serializer.sv
// Directed bench for struct_field_serializer with DEPTH=2.
module tb_struct_field_serializer;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_data;
   logic       out_last;
   logic [1:0] fifo_count;

   int checks;
   int errors;

   struct_field_serializer #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input logic v, input logic [1:0] d, input logic l);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      if (v) begin
         check({tag, ".data"}, 32'(out_data), 32'(d));
         check({tag, ".last"}, 32'(out_last), 32'(l));
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;

      // Reset state
      check("rst.valid", 32'(out_valid), 0);
      check("rst.data", 32'(out_data), 0);
      check("rst.last", 32'(out_last), 0);
      check("rst.count", 32'(fifo_count), 0);
      check("rst.in_ready", 32'(in_ready), 1);

      // Single word 1001: beats 01 then 10
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'b1001;
      step();
      in_valid = 1'b0;
      check("t1.count_push", 32'(fifo_count), 1);
      check("t1.no_beat_yet", 32'(out_valid), 0);
      step();
      beat("t1.b0", 1'b1, 2'b01, 1'b0);
      step();
      beat("t1.b1", 1'b1, 2'b10, 1'b1);
      step();
      beat("t1.end", 1'b0, 2'b00, 1'b0);
      check("t1.count_end", 32'(fifo_count), 0);

      // Back-to-back E then 3 with no bubble
      in_valid = 1'b1;
      in_data  = 4'hE;
      step();
      in_data = 4'h3;
      step();
      in_valid = 1'b0;
      beat("t2.b0", 1'b1, 2'b10, 1'b0);
      check("t2.count", 32'(fifo_count), 2);
      step();
      beat("t2.b1", 1'b1, 2'b11, 1'b1);
      step();
      beat("t2.b2", 1'b1, 2'b11, 1'b0);
      check("t2.count_pop", 32'(fifo_count), 1);
      step();
      beat("t2.b3", 1'b1, 2'b00, 1'b1);
      step();
      beat("t2.end", 1'b0, 2'b00, 1'b0);
      check("t2.count_end", 32'(fifo_count), 0);

      // Fill with consumer stalled: 5 then A, third word refused
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h5;
      step();
      check("t3.in_ready1", 32'(in_ready), 1);
      in_data = 4'hA;
      step();
      check("t3.in_ready_full", 32'(in_ready), 0);
      check("t3.count_full", 32'(fifo_count), 2);
      in_data = 4'hF;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t3.count_hold", 32'(fifo_count), 2);
         beat("t3.stall", 1'b1, 2'b01, 1'b0);
      end
      in_valid = 1'b0;

      // Stall on the last beat of word 5, then release
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      beat("t4.last", 1'b1, 2'b01, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         beat("t4.stall", 1'b1, 2'b01, 1'b1);
         check("t4.count_hold", 32'(fifo_count), 2);
      end
      out_ready = 1'b1;
      step();
      check("t4.count_pop", 32'(fifo_count), 1);
      beat("t4.next_first", 1'b1, 2'b10, 1'b0);
      step();
      beat("t4.next_last", 1'b1, 2'b10, 1'b1);

      // Push C in the same cycle as the last handshake of the only word
      in_valid = 1'b1;
      in_data  = 4'hC;
      step();
      in_valid = 1'b0;
      check("t5.count", 32'(fifo_count), 1);
      check("t5.bubble", 32'(out_valid), 0);
      step();
      beat("t5.b0", 1'b1, 2'b00, 1'b0);
      step();
      beat("t5.b1", 1'b1, 2'b11, 1'b1);
      step();
      beat("t5.end", 1'b0, 2'b00, 1'b0);
      check("t5.count_end", 32'(fifo_count), 0);

      // Reset while in LAST with two words buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h9;
      step();
      in_data = 4'h7;
      step();
      in_valid = 1'b0;
      beat("t6.first", 1'b1, 2'b01, 1'b0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      beat("t6.last", 1'b1, 2'b10, 1'b1);
      check("t6.count_pre", 32'(fifo_count), 2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6.rst_valid", 32'(out_valid), 0);
      check("t6.rst_count", 32'(fifo_count), 0);
      check("t6.rst_in_ready", 32'(in_ready), 1);
      check("t6.rst_last", 32'(out_last), 0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 4'h6;
      step();
      in_valid = 1'b0;
      check("t6.count_new", 32'(fifo_count), 1);
      step();
      beat("t6.b0", 1'b1, 2'b10, 1'b0);
      step();
      beat("t6.b1", 1'b1, 2'b01, 1'b1);
      step();
      beat("t6.end", 1'b0, 2'b00, 1'b0);
      check("t6.count_end", 32'(fifo_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
